// File: rtl/conv_layer_seq_if.sv
// conv_layer_seq_if: scheduler handshake, MAC result bus and BRAM ports of one conv layer sequencer
// master = sequencer side (drives BRAM controls, busy/done); slave = scheduler/MAC/BRAM side (drives start, wr_data)
interface conv_layer_seq_if #(
  parameter int LANES = 50,
  parameter int OUT_LANES = 56,
  parameter int DATA_W = 16,
  parameter int W_AW = 12,
  parameter int FM_AW = 5,
  parameter int BIAS_AW = 7,
  parameter int OUT_AW = 7
);
  logic start, busy, done;
  logic [2*LANES*(DATA_W+1)-1:0] wr_data;
  logic w_en;
  logic [W_AW-1:0] w_addr;
  logic fm_ena, fm_enb;
  logic [FM_AW-1:0] fm_addra, fm_addrb;
  logic bias_en;
  logic [BIAS_AW-1:0] bias_addr;
  logic out_wea, out_web;
  logic [OUT_AW-1:0] out_addra, out_addrb;
  logic [OUT_LANES*DATA_W-1:0] out_dina, out_dinb;
  modport master (
    input start, wr_data,
    output busy, done, w_en, w_addr, fm_ena, fm_enb, fm_addra, fm_addrb, bias_en, bias_addr,
    output out_wea, out_web, out_addra, out_addrb, out_dina, out_dinb
  );
  modport slave (
    output start, wr_data,
    input busy, done, w_en, w_addr, fm_ena, fm_enb, fm_addra, fm_addrb, bias_en, bias_addr,
    input out_wea, out_web, out_addra, out_addrb, out_dina, out_dinb
  );
endinterface

// File: rtl/conv_layer_seq.sv
// conv_layer_seq: walks N_OUT maps x K_TAPS taps, drives weight/fm/bias reads and writes rounded results to the output BRAM
// ports: clk, rst (sync, active-high), bus (conv_layer_seq_if.master: start/busy/done, wr_data, w_*, fm_*, bias_*, out_*)
module conv_layer_seq #(
  parameter int N_OUT = 8,
  parameter int K_TAPS = 300,
  parameter int LANES = 50,
  parameter int OUT_LANES = 56,
  parameter int DATA_W = 16,
  parameter int W_BASE = 150,
  parameter int W_STRIDE = 1200,
  parameter int W_AW = 12,
  parameter int FM_PERIOD = 50,
  parameter int FM_MID = 10,
  parameter int FM_A_STEP = 3,
  parameter int FM_B_STEP = 2,
  parameter int FM_AW = 5,
  parameter int BIAS_BASE = 4,
  parameter int BIAS_AW = 7,
  parameter int OUT_BASE_A = 0,
  parameter int OUT_BASE_B = 1,
  parameter int OUT_STEP = 16,
  parameter int OUT_AW = 7,
  parameter int RESULT_LAT = 4,
  parameter int RELU_EN = 0
) (
  input logic clk,
  input logic rst,
  conv_layer_seq_if.master bus
);
  localparam int TW = $clog2(K_TAPS + 1);
  localparam int MW = $clog2(N_OUT + 1);
  localparam int PW = $clog2(FM_PERIOD + 1);
  localparam int LW = DATA_W + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [TW-1:0] tap;
  logic [MW-1:0] map, wm;
  logic [PW-1:0] ph;
  logic [RESULT_LAT:0] d;
  logic ob, go, run, last_tap, last_map, lt, restart, step, mid, beat;
  logic [OUT_LANES*DATA_W-1:0] din_a, din_b;
  function automatic logic [DATA_W-1:0] sat(input logic [LW-1:0] l);
    logic [LW-1:0] r;
    r = {l[LW-1], l[LW-1:1]} + {{DATA_W{1'b0}}, l[0]};
    return (!r[LW-1] && r[LW-2]) ? {1'b0, {(DATA_W-1){1'b1}}} : (RELU_EN != 0 && r[LW-1]) ? '0 : r[DATA_W-1:0];
  endfunction
  for (genvar i = 0; i < OUT_LANES; i++) begin : g_lane
    if (i < LANES) begin : g_act
      assign din_a[i*DATA_W +: DATA_W] = sat(bus.wr_data[(LANES+i)*LW +: LW]);
      assign din_b[i*DATA_W +: DATA_W] = sat(bus.wr_data[i*LW +: LW]);
    end else begin : g_pad
      assign din_a[i*DATA_W +: DATA_W] = '0;
      assign din_b[i*DATA_W +: DATA_W] = '0;
    end
  end
  // ph tracks tap % FM_PERIOD without a divider
  always_comb begin
    go = state == IDLE && bus.start;
    run = state == RUN;
    last_tap = tap == TW'(K_TAPS);
    last_map = map == MW'(N_OUT - 1);
    lt = run && last_tap;
    restart = go || (lt && !last_map);
    step = run && !last_tap && ph == '0;
    mid = run && !last_tap && ph == PW'(FM_MID);
    beat = d[RESULT_LAT-1] || d[RESULT_LAT];
  end
  assign bus.busy = run || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.w_en = run;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tap <= '0;
      map <= '0;
      wm <= '0;
      ph <= '0;
      d <= '0;
      ob <= 1'b0;
      bus.w_addr <= '0;
      bus.fm_ena <= 1'b0;
      bus.fm_enb <= 1'b0;
      bus.fm_addra <= '0;
      bus.fm_addrb <= '0;
      bus.bias_en <= 1'b0;
      bus.bias_addr <= '0;
      bus.out_wea <= 1'b0;
      bus.out_web <= 1'b0;
      bus.out_addra <= '0;
      bus.out_addrb <= '0;
      bus.out_dina <= '0;
      bus.out_dinb <= '0;
    end else begin
      // DRAIN ends on the beat-1 write with nothing left in the result pipe
      state <= go ? RUN : (lt && last_map) ? DRAIN :
               (state == DRAIN && bus.out_wea && ob && d == '0) ? DONE : (state == DONE) ? IDLE : state;
      tap <= go ? TW'(1) : run ? (last_tap ? TW'(1) : tap + 1'b1) : tap;
      map <= go ? '0 : lt ? map + 1'b1 : map;
      ph <= restart ? PW'(1 % FM_PERIOD) : run ? (ph == PW'(FM_PERIOD - 1) ? '0 : ph + 1'b1) : ph;
      bus.w_addr <= go ? W_AW'(W_BASE) : run ? (tap[0] ? bus.w_addr + W_AW'(W_STRIDE) : bus.w_addr - W_AW'(W_STRIDE - 1)) : bus.w_addr;
      bus.fm_ena <= restart || step;
      bus.fm_enb <= restart || step || mid;
      bus.fm_addra <= restart ? '0 : step ? bus.fm_addra + FM_AW'(FM_A_STEP) : bus.fm_addra;
      bus.fm_addrb <= restart ? FM_AW'(1) : step ? bus.fm_addrb + FM_AW'(FM_B_STEP) : mid ? bus.fm_addrb + 1'b1 : bus.fm_addrb;
      bus.bias_en <= restart;
      bus.bias_addr <= go ? BIAS_AW'(BIAS_BASE) : bus.bias_en ? bus.bias_addr + 1'b1 : bus.bias_addr;
      // d[k] is the last-tap event delayed k+1 cycles: d[LAT-1] = beat 0, d[LAT] = beat 1
      d <= {d[RESULT_LAT-1:0], lt};
      ob <= d[RESULT_LAT];
      wm <= go ? '0 : d[RESULT_LAT] ? wm + 1'b1 : wm;
      bus.out_wea <= beat;
      bus.out_web <= beat;
      if (beat) begin
        bus.out_addra <= OUT_AW'(OUT_BASE_A) + OUT_AW'(wm) + (d[RESULT_LAT] ? OUT_AW'(OUT_STEP) : '0);
        bus.out_addrb <= OUT_AW'(OUT_BASE_B) + OUT_AW'(wm) + (d[RESULT_LAT] ? OUT_AW'(OUT_STEP) : '0);
        bus.out_dina <= din_a;
        bus.out_dinb <= din_b;
      end
    end
  end
endmodule
